// File: rtl/multicycle_mult.sv
// Multi-cycle shift-add multiplier: sum_out = avg_in * cnt_in.
// The multiplier is consumed K = CNT_WIDTH/MUL_CYCLES bits per CALC cycle,
// LSB first, so the result appears MUL_CYCLES cycles after the operands are taken.
module multicycle_mult #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [WIDTH-1:0]              avg_in,
    input  logic [CNT_WIDTH-1:0]          cnt_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH+CNT_WIDTH-1:0]    sum_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int unsigned PW     = WIDTH + CNT_WIDTH;
    localparam int unsigned K      = CNT_WIDTH / MUL_CYCLES;
    localparam int unsigned STEP_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Reject configurations where the multiplier does not split evenly across cycles
    if ((CNT_WIDTH % MUL_CYCLES) != 0) begin : g_bad_cfg
        $error("multicycle_mult: CNT_WIDTH must be a multiple of MUL_CYCLES");
    end

    logic [1:0]           state_q,     state_d;
    logic [PW-1:0]        mcand_q,     mcand_d;
    logic [CNT_WIDTH-1:0] mplier_q,    mplier_d;
    logic [PW-1:0]        acc_q,       acc_d;
    logic [STEP_W-1:0]    step_q,      step_d;
    logic [PW-1:0]        sum_q,       sum_d;
    logic                 out_valid_q, out_valid_d;

    // Next-state and datapath: capture, K-bit shift-add step, result hand-off
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        step_d      = step_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d  = PW'(avg_in);
                    mplier_d = cnt_in;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                for (int unsigned i = 0; i < K; i++) begin
                    if (mplier_q[i]) begin
                        acc_d = acc_d + (mcand_q << i);
                    end
                end
                mcand_d  = mcand_q << K;
                mplier_d = mplier_q >> K;
                step_d   = step_q + STEP_W'(1);
                if (step_q == STEP_W'(MUL_CYCLES - 1)) begin
                    sum_d       = acc_d;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign sum_out   = sum_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multicycle_mult.sv
// Scoreboard bench for multicycle_mult: three instances (MUL_CYCLES = 1, 4, 8),
// expected products pushed at issue time, a negedge monitor pops and checks.
module tb_multicycle_mult;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  avg_a [3];
    logic [7:0]  cnt_a [3];
    logic        in_valid_a [3];
    logic        in_ready_a [3];
    logic [15:0] sum_a [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic        busy_a [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int val;
        int acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_mult #(.WIDTH(8), .CNT_WIDTH(8), .MUL_CYCLES(1)) u_mc1 (
        .clk(clk), .rstn(rstn), .avg_in(avg_a[0]), .cnt_in(cnt_a[0]),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .sum_out(sum_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .busy(busy_a[0]));

    multicycle_mult #(.WIDTH(8), .CNT_WIDTH(8), .MUL_CYCLES(4)) u_mc4 (
        .clk(clk), .rstn(rstn), .avg_in(avg_a[1]), .cnt_in(cnt_a[1]),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .sum_out(sum_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .busy(busy_a[1]));

    multicycle_mult #(.WIDTH(8), .CNT_WIDTH(8), .MUL_CYCLES(8)) u_mc8 (
        .clk(clk), .rstn(rstn), .avg_in(avg_a[2]), .cnt_in(cnt_a[2]),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .sum_out(sum_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .busy(busy_a[2]));

    function automatic int mc_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
    endfunction

    function automatic void chk(input bit ok, input string nm, input int d,
                                input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d (MUL_CYCLES=%0d) at cycle %0d: got %0d, expected %0d",
                     nm, d, mc_of(d), cyc, act, req);
        end
    endfunction

    function automatic void push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: check results, latency, hold during stall, and post-handshake idle
    bit ov_prev [3];
    bit hs_prev [3];
    int cur_exp [3];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                ov_prev[d] = 1'b0;
                hs_prev[d] = 1'b0;
            end else begin
                if (hs_prev[d]) begin
                    chk(!out_valid_a[d], "post_hs_out_valid", d, longint'(out_valid_a[d]), 0);
                    chk(in_ready_a[d], "post_hs_in_ready", d, longint'(in_ready_a[d]), 1);
                end
                if (out_valid_a[d] && !ov_prev[d]) begin
                    if (q_size(d) == 0) begin
                        chk(1'b0, "unexpected_output", d, longint'(sum_a[d]), -1);
                        cur_exp[d] = int'(sum_a[d]);
                    end else begin
                        exp_t e;
                        e = pop_exp(d);
                        cur_exp[d] = e.val;
                        chk(int'(sum_a[d]) == e.val, "product", d, longint'(sum_a[d]), longint'(e.val));
                        chk(cyc - e.acc == mc_of(d), "latency", d, longint'(cyc - e.acc), longint'(mc_of(d)));
                    end
                end else if (out_valid_a[d]) begin
                    chk(int'(sum_a[d]) == cur_exp[d], "hold_sum", d, longint'(sum_a[d]), longint'(cur_exp[d]));
                end
                if (out_valid_a[d]) begin
                    chk(!in_ready_a[d], "in_ready_in_done", d, longint'(in_ready_a[d]), 0);
                end
                ov_prev[d] = out_valid_a[d];
                hs_prev[d] = out_valid_a[d] && out_ready_a[d];
            end
        end
    end

    // Present one operand pair when the instance is ready; record expected product
    task automatic issue(input int d, input int a, input int c);
        bit got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (in_ready_a[d]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk(1'b0, "issue_timeout", d, 0, 1);
        end else begin
            exp_t e;
            avg_a[d]      = 8'(a);
            cnt_a[d]      = 8'(c);
            in_valid_a[d] = 1'b1;
            e.val = a * c;
            e.acc = cyc + 1;
            push_exp(d, e);
            @(posedge clk); #1;
            in_valid_a[d] = 1'b0;
            avg_a[d]      = 8'($urandom);
            cnt_a[d]      = 8'($urandom);
        end
    endtask

    // Issue and count busy cycles until the block returns to idle
    task automatic run_one(input int d, input int a, input int c);
        int n = 0;
        bit done = 1'b0;
        issue(d, a, c);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (busy_a[d]) n++;
            else begin
                done = 1'b1;
                break;
            end
        end
        chk(done && n == mc_of(d) + 1, "busy_cycles", d, longint'(n), longint'(mc_of(d) + 1));
    endtask

    task automatic wait_idle(input int d);
        bit done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy_a[d]) begin
                done = 1'b1;
                break;
            end
        end
        chk(done, "idle_timeout", d, longint'(busy_a[d]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            avg_a[d]       = '0;
            cnt_a[d]       = '0;
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b1;
        end
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk(sum_a[d] == 16'd0, "reset_sum", d, longint'(sum_a[d]), 0);
            chk(!out_valid_a[d], "reset_out_valid", d, longint'(out_valid_a[d]), 0);
            chk(!busy_a[d], "reset_busy", d, longint'(busy_a[d]), 0);
            chk(in_ready_a[d], "reset_in_ready", d, longint'(in_ready_a[d]), 1);
        end

        // Basic products at each latency, including zero operands
        run_one(0, 200, 100);
        run_one(2, 255, 255);
        run_one(1, 0, 37);
        run_one(1, 91, 0);
        run_one(2, 0, 0);
        run_one(0, 255, 255);

        // Backpressure: hold the result while a second pair is offered and ignored
        out_ready_a[1] = 1'b0;
        issue(1, 17, 3);
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (out_valid_a[1]) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk(seen, "bp_wait_valid", 1, longint'(out_valid_a[1]), 1);
        end
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            in_valid_a[1] = 1'b1;
            avg_a[1]      = 8'd99;
            cnt_a[1]      = 8'd99;
        end
        @(negedge clk);
        chk(out_valid_a[1] && sum_a[1] == 16'd51, "bp_still_held", 1, longint'(sum_a[1]), 51);
        @(posedge clk); #1;
        in_valid_a[1]  = 1'b0;
        out_ready_a[1] = 1'b1;
        wait_idle(1);
        repeat (15) @(negedge clk);
        chk(!busy_a[1] && in_ready_a[1], "bp_back_idle", 1, longint'(busy_a[1]), 0);

        // Reset while in CALC step 3 aborts without presenting anything
        issue(2, 100, 100);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        q2.delete();
        @(negedge clk);
        chk(!out_valid_a[2], "abort_out_valid", 2, longint'(out_valid_a[2]), 0);
        chk(sum_a[2] == 16'd0, "abort_sum", 2, longint'(sum_a[2]), 0);
        chk(in_ready_a[2], "abort_in_ready", 2, longint'(in_ready_a[2]), 1);
        run_one(2, 3, 5);

        // Random round trip on MUL_CYCLES=1 and 4 in parallel
        fork
            begin
                for (int i = 0; i < 1000; i++) run_one(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
            begin
                for (int i = 0; i < 1000; i++) run_one(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
        join

        repeat (20) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk(q_size(d) == 0, "scoreboard_drained", d, longint'(q_size(d)), 0);
        end

        if (n_fail == 0) $display("All Vectors passed");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
